// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and the per-bit logic-op helper for the multi-cycle ALU.
// Opcode encoding matches the original 8-bit ALU so issue stages need no change.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_INC  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_DEC  = 4'd3;
    localparam logic [3:0] ALU_MUL  = 4'd4;
    localparam logic [3:0] ALU_DIV  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_INV  = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_OR   = 4'd10;
    localparam logic [3:0] ALU_NAND = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_XOR  = 4'd13;
    localparam logic [3:0] ALU_XNOR = 4'd14;
    localparam logic [3:0] ALU_BUF  = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } alu_state_t;

    // One bit of the bitwise op group; anything outside the group passes a through.
    function automatic logic alu_bit_op(input logic [3:0] cmd, input logic a, input logic b);
        case (cmd)
            ALU_INV:  return ~a;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NAND: return ~(a & b);
            ALU_NOR:  return ~(a | b);
            ALU_XOR:  return a ^ b;
            ALU_XNOR: return ~(a ^ b);
            default:  return a;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback bus of the ALU: valid/ready on both sides, operands in, result and flags out.
interface alu_mc_if #(parameter int WIDTH = 8);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [3:0]             command;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     y;
    logic                   flag_zero;
    logic                   flag_carry;
    logic                   flag_dz;

    modport master (
        output in_valid, a, b, command, out_ready,
        input  in_ready, out_valid, y, flag_zero, flag_carry, flag_dz
    );

    modport slave (
        input  in_valid, a, b, command, out_ready,
        output in_ready, out_valid, y, flag_zero, flag_carry, flag_dz
    );

endinterface

// File: rtl/alu_div_restoring.sv
// Restoring divider, one quotient bit per clock. The first bit is resolved on the start edge,
// so done pulses WIDTH-1 cycles later with the final quotient/remainder already registered.
module alu_div_restoring #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_reg, quo_reg, dsr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg, done_reg;

    logic [WIDTH-1:0] src_rem, src_quo, src_dsr;
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next, quo_next;

    // On start the iteration works straight from the operands instead of the idle registers.
    always_comb begin
        src_rem  = start ? '0 : rem_reg;
        src_quo  = start ? dividend : quo_reg;
        src_dsr  = start ? divisor : dsr_reg;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        diff     = shifted - {1'b0, src_dsr};
        fits     = (shifted >= {1'b0, src_dsr});
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {src_quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dsr_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg  <= rem_next;
                quo_reg  <= quo_next;
                dsr_reg  <= divisor;
                cnt_reg  <= CNT_W'(WIDTH - 1);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshake: single-cycle datapath for all ops except a
// non-zero DIV, which is handed to the restoring divider while the FSM waits in DIV_RUN.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);

    localparam int W2 = 2 * WIDTH;

    alu_state_t       state_reg;
    logic             in_ready_reg, out_valid_reg;
    logic [W2-1:0]    y_reg;
    logic             zero_reg, carry_reg, dz_reg;

    logic [W2-1:0]    a_ext, b_ext;
    logic [WIDTH-1:0] logic_res;
    logic [W2-1:0]    res_next;
    logic             carry_next;
    logic             accept, div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign a_ext     = {{WIDTH{1'b0}}, bus.a};
    assign b_ext     = {{WIDTH{1'b0}}, bus.b};
    assign accept    = bus.in_valid & in_ready_reg & ~div_busy;
    assign div_start = accept && (bus.command == ALU_DIV) && (bus.b != '0);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign logic_res[gi] = alu_bit_op(bus.command, bus.a[gi], bus.b[gi]);
        end
    endgenerate

    // DIV here only covers the b==0 case; a real division comes back through the divider.
    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        case (bus.command)
            ALU_ADD: begin
                res_next   = a_ext + b_ext;
                carry_next = res_next[WIDTH];
            end
            ALU_INC: begin
                res_next   = a_ext + W2'(1);
                carry_next = res_next[WIDTH];
            end
            ALU_SUB: begin
                res_next   = a_ext - b_ext;
                carry_next = (bus.a < bus.b);
            end
            ALU_DEC: begin
                res_next   = a_ext - W2'(1);
                carry_next = (bus.a == '0);
            end
            ALU_MUL: res_next = a_ext * b_ext;
            ALU_DIV: res_next = {bus.a, {WIDTH{1'b1}}};
            ALU_SHL: res_next = (b_ext >= W2'(W2)) ? '0 : (a_ext << b_ext);
            ALU_SHR: res_next = (b_ext >= W2'(W2)) ? '0 : (a_ext >> b_ext);
            default: res_next = {{WIDTH{1'b0}}, logic_res};
        endcase
    end

    alu_div_restoring #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            dz_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (div_start) begin
                            state_reg <= DIV_RUN;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            y_reg         <= res_next;
                            zero_reg      <= (res_next == '0);
                            carry_reg     <= carry_next;
                            dz_reg        <= (bus.command == ALU_DIV);
                        end
                    end
                end
                DIV_RUN: begin
                    if (div_done) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        y_reg         <= {div_rem, div_quo};
                        zero_reg      <= ({div_rem, div_quo} == '0);
                        carry_reg     <= 1'b0;
                        dz_reg        <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.y          = y_reg;
    assign bus.flag_zero  = zero_reg;
    assign bus.flag_carry = carry_reg;
    assign bus.flag_dz    = dz_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        c;
        logic        dz;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(8))  bus8 ();
    alu_mc_if #(.WIDTH(16)) bus16 ();

    alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    res_t q8[$];
    res_t q16[$];
    res_t last8, last16;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, then masked to the 2*w-bit result.
    function automatic res_t model(input int w, input logic [3:0] cmd,
                                   input logic [63:0] a, input logic [63:0] b);
        res_t        r;
        logic [63:0] mask, hmask, v;
        mask  = (64'd1 << (2 * w)) - 64'd1;
        hmask = (64'd1 << w) - 64'd1;
        v = '0; r.c = 1'b0; r.dz = 1'b0;
        case (cmd)
            ALU_ADD:  begin v = a + b;      r.c = v[w]; end
            ALU_INC:  begin v = a + 64'd1;  r.c = v[w]; end
            ALU_SUB:  begin v = a - b;      r.c = (a < b); end
            ALU_DEC:  begin v = a - 64'd1;  r.c = (a == 0); end
            ALU_MUL:  v = a * b;
            ALU_DIV:  begin
                if (b == 0) begin v = (a << w) | hmask; r.dz = 1'b1; end
                else v = ((a % b) << w) | (a / b);
            end
            ALU_SHL:  v = (b >= 64'(2 * w)) ? 64'd0 : (a << b);
            ALU_SHR:  v = (b >= 64'(2 * w)) ? 64'd0 : (a >> b);
            ALU_INV:  v = ~a & hmask;
            ALU_AND:  v = a & b;
            ALU_OR:   v = a | b;
            ALU_NAND: v = ~(a & b) & hmask;
            ALU_NOR:  v = ~(a | b) & hmask;
            ALU_XOR:  v = a ^ b;
            ALU_XNOR: v = ~(a ^ b) & hmask;
            default:  v = a;
        endcase
        v   = v & mask;
        r.y = v[31:0];
        r.z = (v == 0);
        return r;
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 8) ? bus8.out_valid : bus16.out_valid;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 8) ? bus8.in_ready : bus16.in_ready;
    endfunction

    task automatic drive(input int w, input logic v, input logic [3:0] cmd,
                         input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            bus8.in_valid = v; bus8.command = cmd; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus16.in_valid = v; bus16.command = cmd; bus16.a = a; bus16.b = b;
        end
    endtask

    task automatic set_ordy(input int w, input logic v);
        if (w == 8) bus8.out_ready = v;
        else        bus16.out_ready = v;
    endtask

    // Issue one op, check its latency, optionally hold out_ready low for 'hold' extra cycles.
    task automatic run_op(input int w, input logic [3:0] cmd, input logic [15:0] a,
                          input logic [15:0] b, input int hold);
        int   k, lat, exp_lat;
        res_t e;
        k = 0;
        while (!get_ir(w) && k < 50) begin @(posedge clk); #1; k++; end
        if (k >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready timeout w%0d: got 0, expected 1", w);
        end
        e       = model(w, cmd, 64'(a), 64'(b));
        exp_lat = (cmd == ALU_DIV && b != 16'd0) ? w + 1 : 1;
        set_ordy(w, hold == 0);
        drive(w, 1'b1, cmd, a, b);
        @(posedge clk);
        if (w == 8) q8.push_back(e); else q16.push_back(e);
        #1;
        drive(w, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
        lat = 1;
        while (!get_ov(w) && lat < 40) begin @(posedge clk); #1; lat++; end
        check($sformatf("latency w%0d cmd%0d", w, cmd), 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            set_ordy(w, 1'b1);
        end
        @(posedge clk); #1;
        check($sformatf("in_ready after handshake w%0d", w), 32'(get_ir(w)), 32'd1);
        check($sformatf("out_valid after handshake w%0d", w), 32'(get_ov(w)), 32'd0);
    endtask

    // Single compare process: every cycle a result is presented it must match the model head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL w8 spurious out_valid: got 1, expected 0");
                end else begin
                    check("w8 y", 32'(bus8.y), q8[0].y);
                    check("w8 flag_zero", 32'(bus8.flag_zero), 32'(q8[0].z));
                    check("w8 flag_carry", 32'(bus8.flag_carry), 32'(q8[0].c));
                    check("w8 flag_dz", 32'(bus8.flag_dz), 32'(q8[0].dz));
                    check("w8 in_ready while busy", 32'(bus8.in_ready), 32'd0);
                    if (bus8.out_ready) begin
                        last8.y = 32'(bus8.y); last8.z = bus8.flag_zero;
                        last8.c = bus8.flag_carry; last8.dz = bus8.flag_dz;
                        $display("txn w8  y=%h z=%b c=%b dz=%b", bus8.y, bus8.flag_zero,
                                 bus8.flag_carry, bus8.flag_dz);
                        void'(q8.pop_front());
                    end
                end
            end
            if (bus16.out_valid) begin
                if (q16.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL w16 spurious out_valid: got 1, expected 0");
                end else begin
                    check("w16 y", bus16.y, q16[0].y);
                    check("w16 flag_zero", 32'(bus16.flag_zero), 32'(q16[0].z));
                    check("w16 flag_carry", 32'(bus16.flag_carry), 32'(q16[0].c));
                    check("w16 flag_dz", 32'(bus16.flag_dz), 32'(q16[0].dz));
                    check("w16 in_ready while busy", 32'(bus16.in_ready), 32'd0);
                    if (bus16.out_ready) begin
                        last16.y = bus16.y; last16.z = bus16.flag_zero;
                        last16.c = bus16.flag_carry; last16.dz = bus16.flag_dz;
                        $display("txn w16 y=%h z=%b c=%b dz=%b", bus16.y, bus16.flag_zero,
                                 bus16.flag_carry, bus16.flag_dz);
                        void'(q16.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        res_t m;
        logic seen;

        m = model(8, ALU_DIV, 64'd200, 64'd7);   check("model div 200/7", m.y, 32'h041C);
        m = model(8, ALU_DIV, 64'd5, 64'd0);     check("model div 5/0", m.y, 32'h05FF);
        m = model(8, ALU_SUB, 64'd3, 64'd5);     check("model sub 3-5", m.y, 32'hFFFE);
        m = model(16, ALU_SHL, 64'd1, 64'd32);   check("model shl w16 by 32", m.y, 32'h0);

        rst = 1'b1;
        drive(8, 1'b0, 4'd0, 16'd0, 16'd0);
        drive(16, 1'b0, 4'd0, 16'd0, 16'd0);
        set_ordy(8, 1'b1); set_ordy(16, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus8.in_ready), 32'd1);
        check("reset out_valid", 32'(bus8.out_valid), 32'd0);
        check("reset y", 32'(bus8.y), 32'd0);
        check("reset flags", 32'({bus8.flag_zero, bus8.flag_carry, bus8.flag_dz}), 32'd0);
        check("reset w16 y/valid", {15'd0, bus16.out_valid, bus16.y[15:0]}, 32'd0);
        rst = 1'b0;

        run_op(8, ALU_ADD, 16'hFF, 16'h01, 0);
        check("add ff+1 y", last8.y, 32'h0100);
        check("add ff+1 carry", 32'(last8.c), 32'd1);
        check("add ff+1 zero", 32'(last8.z), 32'd0);

        run_op(8, ALU_DIV, 16'd200, 16'd7, 0);
        check("div 200/7 y", last8.y, 32'h041C);
        check("div 200/7 dz", 32'(last8.dz), 32'd0);

        run_op(8, ALU_DIV, 16'd5, 16'd0, 0);
        check("div 5/0 y", last8.y, 32'h05FF);
        check("div 5/0 dz", 32'(last8.dz), 32'd1);

        run_op(8, ALU_MUL, 16'hFF, 16'hFF, 5);
        check("mul ff*ff y", last8.y, 32'hFE01);

        // Abort a DIV with reset on its fourth cycle; nothing may come out.
        drive(8, 1'b1, ALU_DIV, 16'd255, 16'd3);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 4'd0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q8.delete();
        check("abort in_ready", 32'(bus8.in_ready), 32'd1);
        check("abort y", 32'(bus8.y), 32'd0);
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; seen = seen | bus8.out_valid; end
        check("abort no out_valid", 32'(seen), 32'd0);

        run_op(8, ALU_SUB, 16'd3, 16'd5, 0);
        check("sub 3-5 y", last8.y, 32'hFFFE);
        check("sub 3-5 carry", 32'(last8.c), 32'd1);

        run_op(8, ALU_INC, 16'hFF, 16'h00, 0);
        run_op(8, ALU_DEC, 16'h00, 16'h00, 0);
        run_op(8, ALU_SUB, 16'h55, 16'h55, 0);
        check("sub equal zero", 32'(last8.z), 32'd1);
        run_op(8, ALU_SHL, 16'h01, 16'd15, 0);
        run_op(8, ALU_SHL, 16'h01, 16'd16, 0);
        run_op(8, ALU_SHR, 16'h80, 16'd3, 0);
        run_op(8, ALU_DIV, 16'd255, 16'd255, 0);
        run_op(8, ALU_DIV, 16'd7, 16'd200, 0);
        for (int c = 8; c < 16; c++) run_op(8, 4'(c), 16'h00C5, 16'h003A, 0);

        run_op(16, ALU_ADD, 16'hFFFF, 16'h0001, 0);
        run_op(16, ALU_SHL, 16'h0001, 16'd32, 0);
        check("w16 shl by 32 y", last16.y, 32'h0);
        run_op(16, ALU_SHL, 16'hABCD, 16'd31, 0);
        run_op(16, ALU_SHR, 16'hABCD, 16'd4, 2);
        run_op(16, ALU_MUL, 16'hFFFF, 16'hFFFF, 0);
        run_op(16, ALU_DIV, 16'hFFFF, 16'd3, 0);
        run_op(16, ALU_DIV, 16'h1234, 16'h0000, 0);
        run_op(16, ALU_DEC, 16'h0000, 16'h0000, 0);
        run_op(16, ALU_XNOR, 16'hF0F0, 16'h0FF0, 0);
        for (int i = 0; i < 6; i++)
            run_op(16, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom_range(0, 40)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
